// File: rtl/sap_pkg.sv
// Shared types and widths for the SAP front-panel RAM loader.
package sap_pkg;
    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR,
        LOCKED
    } loader_state_t;
endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter.
// Emits a one-cycle press pulse on an accepted release-to-press change.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // accepted level change; only a new press is reported
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_loader_ctrl.sv
// Front-panel loader for the SAP RAM: debounced buttons drive
// single writes, address moves and a full clear sweep.
module ram_loader_ctrl
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ADDR_W          = SAP_ADDR_W,
    parameter int DATA_W          = SAP_DATA_W,
    parameter int AUTO_INC        = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              programm_run,
    input  logic              btn_write,
    input  logic              btn_next,
    input  logic              btn_addr,
    input  logic              btn_clear,
    input  logic [ADDR_W-1:0] addr_dip,
    input  logic [DATA_W-1:0] ram_dip,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_we,
    output logic              busy,
    output logic              locked
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP     = (AUTO_INC != 0) ? ONE : '0;

    logic          p_write;
    logic          p_next;
    logic          p_addr;
    logic          p_clear;
    loader_state_t state;
    loader_state_t state_n;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_write (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_write), .press(p_write)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_next), .press(p_next)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_addr (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_addr), .press(p_addr)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock(clock), .reset_n(reset_n), .btn_raw(btn_clear), .press(p_clear)
    );

    always_comb begin
        state_n = state;
        ld_we   = 1'b0;
        busy    = 1'b0;
        locked  = 1'b0;
        unique case (state)
            IDLE: begin
                if (programm_run)  state_n = LOCKED;
                else if (p_clear)  state_n = CLEAR;
                else if (p_write)  state_n = WRITE;
            end
            WRITE: begin
                ld_we   = 1'b1;
                busy    = 1'b1;
                state_n = programm_run ? LOCKED : IDLE;
            end
            CLEAR: begin
                busy = 1'b1;
                // the CPU takes the RAM back within the same cycle
                if (programm_run) begin
                    state_n = LOCKED;
                end else begin
                    ld_we = 1'b1;
                    if (ld_addr == ADDR_MAX) state_n = IDLE;
                end
            end
            LOCKED: begin
                locked = 1'b1;
                if (!programm_run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ld_addr <= '0;
            ld_data <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (!programm_run) begin
                        if (p_clear) begin
                            ld_addr <= '0;
                            ld_data <= '0;
                        end else if (p_write) begin
                            ld_data <= ram_dip;
                        end else if (p_addr) begin
                            ld_addr <= addr_dip;
                        end else if (p_next) begin
                            ld_addr <= ld_addr + ONE;
                        end
                    end
                end
                WRITE: ld_addr <= ld_addr + STEP;
                CLEAR: begin
                    if (programm_run || ld_addr == ADDR_MAX) ld_addr <= '0;
                    else ld_addr <= ld_addr + ONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Randomised bench for ram_loader_ctrl with a behavioural
// address/memory model and a strobe log.
module tb_ram_loader_ctrl;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       programm_run = 1'b0;
    logic       btn_write = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_addr = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] addr_dip = '0;
    logic [7:0] ram_dip = '0;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_we;
    logic       busy;
    logic       locked;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [11:0] sq[$];
    int          sc[$];
    logic [7:0]  mem_act[16];
    logic [7:0]  mem_exp[16];
    logic [3:0]  m_addr;

    ram_loader_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset_n(reset_n), .programm_run(programm_run),
        .btn_write(btn_write), .btn_next(btn_next), .btn_addr(btn_addr),
        .btn_clear(btn_clear), .addr_dip(addr_dip), .ram_dip(ram_dip),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_we(ld_we),
        .busy(busy), .locked(locked)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n && ld_we) begin
            sq.push_back({ld_addr, ld_data});
            sc.push_back(cyc);
            mem_act[ld_addr] = ld_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout global");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_write = v;
            1: btn_next  = v;
            2: btn_addr  = v;
            default: btn_clear = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        tick(hold);
        set_btn(b, 1'b0);
        tick(D + 6);
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (sq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (sq.size() < n) begin
            errors++;
            $display("FAIL %s_wait got=%0d strobes need=%0d", tag, sq.size(), n);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        programm_run = 1'b0;
        btn_write = 1'b0;
        btn_next = 1'b0;
        btn_addr = 1'b0;
        btn_clear = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        m_addr = '0;
        sq.delete();
        sc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ld_addr, ld_data} !== 12'h000) begin
            errors++;
            $display("FAIL rst_addr_data got=%h exp=000", {ld_addr, ld_data});
        end
        checks++;
        if ({ld_we, busy, locked} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got=%b exp=000", {ld_we, busy, locked});
        end
    endtask

    task automatic test_write_basic();
        sq.delete();
        ram_dip = 8'hA5;
        press(0, 10);
        mem_exp[m_addr] = 8'hA5;
        checks++;
        if (sq.size() != 1 || sq[0] !== {m_addr, 8'hA5}) begin
            errors++;
            $display("FAIL write_strobe n=%0d got=%h exp=%h", sq.size(),
                     sq.size() > 0 ? sq[0] : 12'hxxx, {m_addr, 8'hA5});
        end
        m_addr = m_addr + 4'd1;
        checks++;
        if (ld_addr !== m_addr || ld_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_after got=%h/%h exp=%h/a5", ld_addr, ld_data, m_addr);
        end
    endtask

    task automatic test_addr_wrap();
        sq.delete();
        addr_dip = 4'hF;
        press(2, 10);
        m_addr = 4'hF;
        checks++;
        if (sq.size() != 0 || ld_addr !== m_addr) begin
            errors++;
            $display("FAIL addr_load n=%0d got=%h exp=%h", sq.size(), ld_addr, m_addr);
        end
        ram_dip = 8'h3C;
        press(0, 10);
        mem_exp[m_addr] = 8'h3C;
        checks++;
        if (sq.size() != 1 || sq[0] !== {m_addr, 8'h3C}) begin
            errors++;
            $display("FAIL wrap_strobe n=%0d got=%h exp=%h", sq.size(),
                     sq.size() > 0 ? sq[0] : 12'hxxx, {m_addr, 8'h3C});
        end
        m_addr = m_addr + 4'd1;
        checks++;
        if (ld_addr !== 4'h0) begin
            errors++;
            $display("FAIL wrap_addr got=%h exp=0", ld_addr);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] dip;
        sq.delete();
        dip = 8'($urandom);
        ram_dip = dip;
        btn_write = 1'b1;
        tick(1);
        btn_write = 1'b0;
        tick(1);
        btn_write = 1'b1;
        tick(12);
        btn_write = 1'b0;
        tick(D + 6);
        mem_exp[m_addr] = dip;
        checks++;
        if (sq.size() != 1 || sq[0] !== {m_addr, dip}) begin
            errors++;
            $display("FAIL bounce n=%0d got=%h exp=%h", sq.size(),
                     sq.size() > 0 ? sq[0] : 12'hxxx, {m_addr, dip});
        end
        m_addr = m_addr + 4'd1;
    endtask

    task automatic test_clear();
        sq.delete();
        sc.delete();
        btn_clear = 1'b1;
        wait_strobes(16, 60, "clear");
        tick(3);
        btn_clear = 1'b0;
        tick(D + 6);
        checks++;
        if (sq.size() != 16) begin
            errors++;
            $display("FAIL clear_count got=%0d exp=16", sq.size());
        end
        for (int i = 0; i < 16 && i < sq.size(); i++) begin
            checks++;
            if (sq[i] !== {4'(i), 8'h00} || sc[i] != sc[0] + i) begin
                errors++;
                $display("FAIL clear_seq%0d got=%h@%0d exp=%h@%0d", i, sq[i],
                         sc[i], {4'(i), 8'h00}, sc[0] + i);
            end
        end
        for (int i = 0; i < 16; i++) mem_exp[i] = 8'h00;
        m_addr = 4'h0;
        checks++;
        if (ld_addr !== m_addr || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end got=%h/%b exp=0/0", ld_addr, busy);
        end
    endtask

    task automatic test_clear_abort();
        sq.delete();
        btn_clear = 1'b1;
        wait_strobes(5, 60, "abort");
        programm_run = 1'b1;
        btn_clear = 1'b0;
        tick(1);
        checks++;
        if (sq.size() != 5) begin
            errors++;
            $display("FAIL abort_count got=%0d exp=5", sq.size());
        end
        for (int i = 0; i < 5 && i < sq.size(); i++) begin
            checks++;
            if (sq[i] !== {4'(i), 8'h00}) begin
                errors++;
                $display("FAIL abort_seq%0d got=%h exp=%h", i, sq[i], {4'(i), 8'h00});
            end
        end
        m_addr = 4'h0;
        checks++;
        if ({locked, busy, ld_we} !== 3'b100 || ld_addr !== m_addr) begin
            errors++;
            $display("FAIL abort_lock got=%b/%h exp=100/0", {locked, busy, ld_we}, ld_addr);
        end
        ram_dip = 8'h77;
        press(0, 10);
        checks++;
        if (sq.size() != 5 || locked !== 1'b1) begin
            errors++;
            $display("FAIL locked_write n=%0d locked=%b exp=5/1", sq.size(), locked);
        end
        programm_run = 1'b0;
        tick(D + 4);
        checks++;
        if (sq.size() != 5 || {locked, busy} !== 2'b00 || ld_addr !== m_addr) begin
            errors++;
            $display("FAIL unlock n=%0d flags=%b addr=%h exp=5/00/%h", sq.size(),
                     {locked, busy}, ld_addr, m_addr);
        end
    endtask

    task automatic test_simultaneous();
        int bad;
        sq.delete();
        ram_dip = 8'hFF;
        btn_clear = 1'b1;
        btn_write = 1'b1;
        wait_strobes(16, 60, "simul");
        btn_clear = 1'b0;
        btn_write = 1'b0;
        tick(D + 10);
        bad = 0;
        foreach (sq[i]) if (sq[i][7:0] !== 8'h00) bad++;
        checks++;
        if (sq.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL simul n=%0d nonzero=%0d exp=16/0", sq.size(), bad);
        end
        checks++;
        if (ld_addr !== m_addr) begin
            errors++;
            $display("FAIL simul_addr got=%h exp=%h", ld_addr, m_addr);
        end
        sq.delete();
        btn_clear = 1'b1;
        wait_strobes(1, 40, "rst_clear");
        btn_clear = 1'b0;
        wait_strobes(3, 10, "rst_clear3");
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ld_addr, ld_data} !== 12'h000 || {ld_we, busy, locked} !== 3'b000) begin
            errors++;
            $display("FAIL async_rst got=%h/%b exp=000/000", {ld_addr, ld_data},
                     {ld_we, busy, locked});
        end
        tick(2);
        reset_n = 1'b1;
        tick(D + 10);
        m_addr = 4'h0;
        checks++;
        if (sq.size() != 3 || ld_addr !== m_addr || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst n=%0d addr=%h busy=%b exp=3/0/0", sq.size(),
                     ld_addr, busy);
        end
    endtask

    task automatic test_random();
        int op;
        int exp_n;
        logic [3:0] a;
        logic [7:0] d;
        for (int n = 0; n < 24; n++) begin
            sq.delete();
            op = int'($urandom_range(0, 3));
            a = 4'($urandom);
            d = 8'($urandom);
            addr_dip = a;
            ram_dip = d;
            exp_n = 0;
            if (op == 3) begin
                programm_run = 1'b1;
                tick(2);
                press(0, int'($urandom_range(D + 4, 12)));
                programm_run = 1'b0;
                tick(2);
            end else begin
                press(op == 0 ? 0 : (op == 1 ? 1 : 2),
                      int'($urandom_range(D + 4, 12)));
                case (op)
                    0: begin
                        mem_exp[m_addr] = d;
                        exp_n = 1;
                        m_addr = m_addr + 4'd1;
                    end
                    1: m_addr = m_addr + 4'd1;
                    default: m_addr = a;
                endcase
            end
            checks++;
            if (sq.size() != exp_n || ld_addr !== m_addr) begin
                errors++;
                $display("FAIL rand%0d op=%0d n=%0d addr=%h exp=%0d/%h", n, op,
                         sq.size(), ld_addr, exp_n, m_addr);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem_act[i] !== mem_exp[i]) begin
                errors++;
                $display("FAIL mem%0d got=%h exp=%h", i, mem_act[i], mem_exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_addr_wrap();
        test_bounce();
        test_clear();
        test_clear_abort();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
